// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer on the reference clock: PLL reset pulse, lock wait with timeout, stability
// qualification, then system reset release; re-inits on lock loss. Optional RETRY_LIMIT_EN adds FAULT.
module pll_reset_ctrl #(
  parameter int POR_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 4096,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 20,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       sw_reset,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] relock_count,
  output logic       fault
);

  localparam logic [CNT_W-1:0] POR_LD = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
`ifdef RETRY_LIMIT_EN
    , S_FAULT
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       relock_d;
  logic             lost_d;
  logic             lk;
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end
  assign lk = sync_q[SYNC_STAGES-1];

`ifdef RETRY_LIMIT_EN
  localparam int RW = $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] retry_q, retry_d;
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_RETRIES != 0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_count;
    lost_d   = 1'b0;
`ifdef RETRY_LIMIT_EN
    retry_d  = retry_q;
`endif
    // sw_reset overrides everything, including a lock drop seen in RUN
    if (sw_reset) begin
      state_d = S_RESET_PLL;
      cnt_d   = POR_LD;
`ifdef RETRY_LIMIT_EN
      retry_d = '0;
`endif
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == '0) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = TO_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state_d = S_STABLE;
            cnt_d   = ST_LD;
          end else if (cnt_q == '0) begin
            state_d = S_RESET_PLL;
            cnt_d   = POR_LD;
`ifdef RETRY_LIMIT_EN
            if (retry_q == RW'(MAX_RETRIES)) state_d = S_FAULT;
            else                             retry_d = retry_q + RW'(1);
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = TO_LD;
          end else if (cnt_q == '0) begin
            state_d = S_RUN;
`ifdef RETRY_LIMIT_EN
            retry_d = '0;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lk) begin
            state_d = S_RESET_PLL;
            cnt_d   = POR_LD;
            lost_d  = 1'b1;
            if (relock_count != 8'hff) relock_d = relock_count + 8'd1;
          end
        end
`ifdef RETRY_LIMIT_EN
        S_FAULT: state_d = S_FAULT;
`endif
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = POR_LD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= POR_LD;
      pll_rst      <= 1'b1;
      sys_reset_n  <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
`ifdef RETRY_LIMIT_EN
      pll_rst      <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
`else
      pll_rst      <= (state_d == S_RESET_PLL);
`endif
      sys_reset_n  <= (state_d == S_RUN);
      ready        <= (state_d == S_RUN);
      lock_lost    <= lost_d;
      relock_count <= relock_d;
    end
  end

`ifdef RETRY_LIMIT_EN
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) fault <= 1'b0;
    else          fault <= (state_d == S_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed sequences plus random lock activity against a mode/age model.
module tb_pll_reset_ctrl;
  localparam int POR = 4, TO = 20, ST = 8, SYNC = 2, MAXR = 2;
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FLT = 4;

  logic refclk = 1'b0;
  logic reset_n, pll_locked, sw_reset;
  logic pll_rst, sys_reset_n, ready, lock_lost, fault;
  logic [7:0] relock_count;

  pll_reset_ctrl #(
    .POR_CYCLES(POR), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST),
    .SYNC_STAGES(SYNC), .CNT_W(20), .MAX_RETRIES(MAXR)
  ) dut (
    .refclk(refclk), .reset_n(reset_n), .pll_locked(pll_locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .ready(ready), .lock_lost(lock_lost),
    .relock_count(relock_count), .fault(fault)
  );

  always #5 refclk = ~refclk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: mode plus cycles spent in it; lk comes from a delay line of raw samples
  int m_mode, m_age, m_retry, m_relock;
  bit m_lost;
  bit lk_line[$];
`ifdef RETRY_LIMIT_EN
  localparam bit LIMITED = 1'b1;
`else
  localparam bit LIMITED = 1'b0;
`endif

  function automatic void model_reset();
    m_mode = M_RST; m_age = 0; m_retry = 0; m_relock = 0; m_lost = 0;
    lk_line = {};
    for (int i = 0; i < SYNC; i++) lk_line.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit lk;
    lk = lk_line[0];
    void'(lk_line.pop_front());
    lk_line.push_back(pll_locked);
    m_lost = 0;
    if (sw_reset) begin
      m_mode = M_RST; m_age = 0; m_retry = 0;
    end else begin
      case (m_mode)
        M_RST:  if (m_age == POR - 1) begin m_mode = M_WAIT; m_age = 0; end else m_age++;
        M_WAIT: if (lk) begin m_mode = M_STAB; m_age = 0; end
                else if (m_age == TO - 1) begin
                  m_age = 0;
                  if (LIMITED && m_retry == MAXR) m_mode = M_FLT;
                  else begin m_mode = M_RST; m_retry++; end
                end else m_age++;
        M_STAB: if (!lk) begin m_mode = M_WAIT; m_age = 0; end
                else if (m_age == ST - 1) begin m_mode = M_RUN; m_age = 0; m_retry = 0; end
                else m_age++;
        M_RUN:  if (!lk) begin
                  m_mode = M_RST; m_age = 0; m_lost = 1;
                  m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                end
        default: ;
      endcase
    end
  endfunction

  task automatic check_outputs();
    chk("pll_rst", pll_rst, (m_mode == M_RST || m_mode == M_FLT));
    chk("sys_reset_n", sys_reset_n, (m_mode == M_RUN));
    chk("ready", ready, (m_mode == M_RUN));
    chk("lock_lost", lock_lost, m_lost);
    chk("relock_count", relock_count, m_relock);
    chk("fault", fault, (m_mode == M_FLT));
  endtask

  task automatic tick();
    model_step();
    @(posedge refclk);
    #1;
    check_outputs();
  endtask

  task automatic wait_ready(input int maxc, output int n, output int rsts);
    n = 0; rsts = 0;
    while (!ready && n < maxc) begin
      tick();
      n++;
      if (pll_rst) rsts++;
    end
    chk("ready_reached", ready, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge refclk); #1;
    check_outputs();
    @(posedge refclk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n, rs, k, lost_n, rst_n_cnt;
    pll_locked = 1'b0; sw_reset = 1'b0;
    do_reset();

    // Power-up: lock raised after edge 10, RUN expected 11 edges later
    for (int i = 0; i < 10; i++) tick();
    pll_locked = 1'b1;
    wait_ready(40, n, rs);
    chk("lock2run", n, SYNC + ST + 1);
    chk("relock_init", relock_count, 0);

    // Glitch during STABLE restarts qualification; PLL never reset
    pll_locked = 1'b0; sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    pll_locked = 1'b1;
    rst_n_cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (pll_rst) rst_n_cnt++; end
    pll_locked = 1'b0;
    tick(); if (pll_rst) rst_n_cnt++;
    pll_locked = 1'b1;
    wait_ready(40, n, rs);
    chk("glitch2run", n, SYNC + ST + 1);
    chk("glitch_pll_rst", rst_n_cnt + rs, 0);

    // Lock loss in RUN, then saturation over 300 losses
    for (int ep = 0; ep < 300; ep++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      k = 1; lost_n = lock_lost; rst_n_cnt = pll_rst;
      while (sys_reset_n && k < 10) begin
        tick(); k++;
        lost_n += lock_lost; rst_n_cnt += pll_rst;
      end
      wait_ready(60, n, rs);
      if (ep == 0) begin
        chk("fall2rst", k, SYNC + 1);
        chk("lost_width", lost_n, 1);
        chk("loss_pll_rst", rst_n_cnt + rs, POR);
        chk("relock_one", relock_count, 1);
      end
    end
    chk("relock_sat", relock_count, 255);

    // sw_reset coincident with lk falling in RUN: no pulse, no increment
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    sw_reset = 1'b1;
    lost_n = 0; rst_n_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); lost_n += lock_lost; rst_n_cnt += pll_rst;
    end
    sw_reset = 1'b0;
    chk("sw_no_lost", lost_n, 0);
    chk("sw_hold_rst", rst_n_cnt, 6);
    chk("sw_relock", relock_count, 255);
    wait_ready(60, n, rs);

    // Asynchronous reset in the middle of WAIT_LOCK
    pll_locked = 1'b0; sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    #3 reset_n = 1'b0;
    #1;
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_reset_n", sys_reset_n, 0);
    chk("async_ready", ready, 0);
    chk("async_lock_lost", lock_lost, 0);
    chk("async_relock", relock_count, 0);
    chk("async_fault", fault, 0);
    model_reset();
    @(posedge refclk); #1;
    reset_n = 1'b1;

    // No lock ever
`ifdef RETRY_LIMIT_EN
    for (int i = 0; i < 90; i++) tick();
    chk("fault_set", fault, 1);
    chk("fault_pll_rst", pll_rst, 1);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    chk("fault_clear", fault, 0);
    k = 0;
    while (pll_rst && k < 10) begin k++; tick(); end
    chk("recover_rst_len", k, POR);
    pll_locked = 1'b1;
    wait_ready(60, n, rs);
`else
    rst_n_cnt = 0;
    for (int i = 0; i < 96; i++) begin tick(); rst_n_cnt += pll_rst; end
    chk("nolock_rst_cycles", rst_n_cnt, 16);
    chk("nolock_fault", fault, 0);
`endif

    // Random lock activity with occasional software resets
    for (int seg = 0; seg < 80; seg++) begin
      pll_locked = 1'($urandom_range(0, 1));
      sw_reset = ($urandom_range(0, 9) == 0);
      k = $urandom_range(1, 30);
      for (int i = 0; i < k; i++) begin
        tick();
        if (sw_reset && $urandom_range(0, 1) == 1) sw_reset = 1'b0;
      end
      sw_reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_reset_ctrl.md
Name: pll_reset_ctrl

Overview:
Sequencer that sits directly in front of the board PLL. It drives the PLL's active-high reset input and consumes its raw lock indicator. It holds the PLL in reset at power-up, waits for lock with a timeout and retry, qualifies lock stability, and only then releases the system reset. It runs on the PLL reference clock so it keeps working while the PLL outputs are dead, and it detects loss of lock in RUN and re-initialises the PLL.

Parameters:
- POR_CYCLES, 64: refclk cycles pll_rst is held high on each PLL reset pulse (min 2).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- STABLE_CYCLES, 4096: consecutive synchronised-locked cycles required before release.
- SYNC_STAGES, 2: flops in the pll_locked synchroniser (min 2).
- CNT_W, 20: width of the shared down-counter; must hold max(POR_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- MAX_RETRIES, 8: timeout retries before FAULT; used only with RETRY_LIMIT_EN.

Ports:
- refclk  in  1  reference clock (50 MHz board clock)
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  raw PLL lock, asynchronous to refclk
- sw_reset  in  1  synchronous request to re-initialise the PLL, level-sensitive
- pll_rst  out  1  active-high reset to the PLL
- sys_reset_n  out  1  active-low system reset, registered
- ready  out  1  high only in RUN
- lock_lost  out  1  one-cycle pulse when lock drops in RUN
- relock_count  out  8  saturating count of lock losses seen in RUN
- fault  out  1  retry limit exhausted

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State = RESET_PLL, counter = POR_CYCLES-1.
  - pll_rst=1, sys_reset_n=0, ready=0, lock_lost=0, relock_count=0, fault=0.
  - Synchroniser flops = 0.
- pll_locked passes through SYNC_STAGES flops; "lk" below means the synchronised value. All outputs are registered.
- RESET_PLL:
  - pll_rst=1, sys_reset_n=0.
  - Counter decrements each cycle; at 0, go to WAIT_LOCK and load LOCK_TIMEOUT-1.
- WAIT_LOCK:
  - pll_rst=0, sys_reset_n=0.
  - If lk=1, go to STABLE and load STABLE_CYCLES-1.
  - Otherwise decrement. At 0 with lk=0, it is a timeout: go to RESET_PLL and load POR_CYCLES-1.
  - If lk=1 and the counter reaches 0 in the same cycle, lk wins.
- STABLE:
  - pll_rst=0, sys_reset_n=0.
  - If lk=0, return to WAIT_LOCK and reload LOCK_TIMEOUT-1. The full timeout restarts; this does not count as a retry.
  - Otherwise decrement; at 0 go to RUN.
- RUN:
  - sys_reset_n=1, ready=1, pll_rst=0.
  - If lk=0: pulse lock_lost for exactly one cycle, increment relock_count (saturates at 255, never wraps), go to RESET_PLL, load POR_CYCLES-1.
  - sys_reset_n and ready fall on the same edge lock_lost rises.
- sw_reset=1 in any state:
  - Next state is RESET_PLL, counter loaded to POR_CYCLES-1, held there while sw_reset stays high.
  - relock_count and lock_lost are unaffected.
  - sw_reset takes priority over every other transition, including a lk drop in RUN. In that case no lock_lost pulse is issued and there is no increment.
- Latency:
  - A pll_locked rise reaches RUN after SYNC_STAGES + STABLE_CYCLES + 1 cycles (±1).
  - A pll_locked fall in RUN deasserts sys_reset_n after SYNC_STAGES + 1 cycles.

Optional Feature:
- Macro: RETRY_LIMIT_EN.
- Defined:
  - A retry counter (width clog2(MAX_RETRIES+1)) increments on each WAIT_LOCK timeout.
  - When a timeout occurs with the counter at MAX_RETRIES, go to FAULT instead of RESET_PLL.
  - FAULT holds pll_rst=1, sys_reset_n=0, fault=1. It is exited only by reset_n or sw_reset, both of which go to RESET_PLL and clear the retry counter and fault.
  - The retry counter also clears on entry to RUN.
- Undefined:
  - Retries are unlimited, fault is tied 0, and the FAULT state and retry counter are absent.

Test Plan:
Bench parameters: POR_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYNC_STAGES=2.
1. Power-up: release reset_n, raise pll_locked at cycle 10 and hold → pll_rst high for exactly cycles 0-3; sys_reset_n and ready rise about 11 cycles after the lock rise; relock_count=0.
2. Lock glitch in STABLE: pll_locked high 5 cycles, low 1, then high → no release until 8 consecutive lk cycles after the glitch; pll_rst stays 0.
3. Lock loss in RUN: drop pll_locked for 1 cycle → lock_lost exactly one cycle wide; relock_count=1; pll_rst high 4 cycles; re-enters RUN after relock. Repeat 300 times → relock_count stays 255.
4. No lock ever (macro off): pll_locked=0 → pll_rst pulses 4 high, 20 low, periodically forever; fault=0.
5. Macro on, MAX_RETRIES=2, no lock → after the 3rd timeout fault=1 and pll_rst held high; pulse sw_reset → fault=0, 4-cycle pll_rst, normal sequence resumes.
6. sw_reset asserted in RUN on the same cycle lk falls → no lock_lost pulse; relock_count unchanged; RESET_PLL held while sw_reset is high. Assert reset_n mid-WAIT_LOCK → all outputs return to their reset values immediately (asynchronously).
